// File: rtl/mac_pkg.sv
// Shared definitions for the MAC datapath: width helpers, saturation limits
// and the lane slicing macro used by the MAC and the requantisation stage.
`ifndef MAC_LANE
`define MAC_LANE(vec, i, w) vec[(i)*(w) +: (w)]
`endif

package mac_pkg;

  // Width of the exact sum of `lanes` products of two in_w-bit signed values.
  function automatic int sum_w(input int in_w, input int lanes);
    return 2 * in_w + $clog2(lanes);
  endfunction

  // Largest signed value representable in acc_w bits (acc_w <= 127).
  function automatic logic signed [127:0] sat_max(input int acc_w);
    return (128'sd1 <<< (acc_w - 1)) - 128'sd1;
  endfunction

  // Smallest signed value representable in acc_w bits (acc_w <= 127).
  function automatic logic signed [127:0] sat_min(input int acc_w);
    return -(128'sd1 <<< (acc_w - 1));
  endfunction

endpackage

// File: rtl/mac_adder_tree.sv
// Combinational binary reduction of LANES packed signed products to SUM_W
// bits. Nodes are kept in heap order: leaves at LANES-1..2*LANES-2, node k
// sums its children 2k+1 and 2k+2, the root is node 0.
module mac_adder_tree
  import mac_pkg::*;
#(
  parameter int LANES = 4,
  parameter int IN_W  = 8,
  localparam int PROD_W = 2 * IN_W,
  localparam int SUM_W  = sum_w(IN_W, LANES)
) (
  input  logic [LANES*PROD_W-1:0] prods,
  output logic signed [SUM_W-1:0] sum
);

  logic signed [SUM_W-1:0] node [2*LANES-1];

  // Leaves: sign-extend each product to the full sum width so no level can overflow.
  for (genvar gi = 0; gi < LANES; gi++) begin : g_leaf
    logic signed [PROD_W-1:0] prod_l;
    assign prod_l               = `MAC_LANE(prods, gi, PROD_W);
    assign node[LANES - 1 + gi] = SUM_W'(prod_l);
  end

  // Internal nodes: pairwise sums up to the root.
  for (genvar gi = 0; gi < LANES - 1; gi++) begin : g_node
    assign node[gi] = node[2*gi + 1] + node[2*gi + 2];
  end

  assign sum = node[0];

endmodule

// File: rtl/mac_vec_acc.sv
// Vector multiply-accumulate: LANES signed products per beat, registered
// adder tree, wide accumulator with optional saturation and a sticky overflow
// flag, one result per in_last-framed dot product on a valid/ready port.
// Pipeline: M (products) -> S (tree sum) -> A (accumulate, result capture)
// -> output register. A single enable stalls every stage together.
module mac_vec_acc
  import mac_pkg::*;
#(
  parameter int LANES    = 4,
  parameter int IN_W     = 8,
  parameter int ACC_W    = 32,
  parameter int SATURATE = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [LANES*IN_W-1:0] in_a,
  input  logic [LANES*IN_W-1:0] in_b,
  input  logic                  in_last,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ACC_W-1:0]      out_data,
  output logic                  out_ovf
);

  localparam int PROD_W = 2 * IN_W;
  localparam int SUM_W  = sum_w(IN_W, LANES);
  localparam int ACC_W1 = ACC_W + 1;
  localparam logic signed [ACC_W-1:0] ACC_MAX = ACC_W'(sat_max(ACC_W));
  localparam logic signed [ACC_W-1:0] ACC_MIN = ACC_W'(sat_min(ACC_W));

  if (ACC_W < SUM_W) begin : g_chk_acc_w
    $error("mac_vec_acc: ACC_W must be at least 2*IN_W + log2(LANES)");
  end
  if (LANES < 1 || (LANES & (LANES - 1)) != 0) begin : g_chk_lanes
    $error("mac_vec_acc: LANES must be a power of two");
  end

  logic                      en;
  logic [LANES*PROD_W-1:0]   prod_next;
  logic [LANES*PROD_W-1:0]   prod_reg;
  logic                      m_valid_reg;
  logic                      m_last_reg;
  logic signed [SUM_W-1:0]   tree_sum;
  logic signed [SUM_W-1:0]   sum_reg;
  logic                      s_valid_reg;
  logic                      s_last_reg;
  logic signed [ACC_W-1:0]   acc_reg;
  logic                      ovf_reg;
  logic signed [ACC_W1-1:0]  acc_wide;
  logic signed [ACC_W-1:0]   acc_next;
  logic                      this_ovf;
  logic                      ovf_next;
  logic                      res_valid_reg;
  logic [ACC_W-1:0]          res_data_reg;
  logic                      res_ovf_reg;
  logic                      out_valid_reg;
  logic [ACC_W-1:0]          out_data_reg;
  logic                      out_ovf_reg;

  // Whole pipeline moves only when the output register is free or being drained.
  assign en       = !out_valid_reg | out_ready;
  assign in_ready = en;

  // Per-lane signed multipliers feeding the M stage.
  for (genvar gi = 0; gi < LANES; gi++) begin : g_mul
    logic signed [IN_W-1:0]   a_l;
    logic signed [IN_W-1:0]   b_l;
    logic signed [PROD_W-1:0] p_l;
    assign a_l = `MAC_LANE(in_a, gi, IN_W);
    assign b_l = `MAC_LANE(in_b, gi, IN_W);
    assign p_l = PROD_W'(a_l) * PROD_W'(b_l);
    assign `MAC_LANE(prod_next, gi, PROD_W) = p_l;
  end

  // M stage: capture products and beat tags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid_reg <= 1'b0;
      m_last_reg  <= 1'b0;
      prod_reg    <= '0;
    end else if (en) begin
      m_valid_reg <= in_valid;
      m_last_reg  <= in_last;
      prod_reg    <= prod_next;
    end
  end

  mac_adder_tree #(
    .LANES (LANES),
    .IN_W  (IN_W)
  ) u_tree (
    .prods (prod_reg),
    .sum   (tree_sum)
  );

  // S stage: capture the reduced sum and tags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_valid_reg <= 1'b0;
      s_last_reg  <= 1'b0;
      sum_reg     <= '0;
    end else if (en) begin
      s_valid_reg <= m_valid_reg;
      s_last_reg  <= m_last_reg;
      sum_reg     <= tree_sum;
    end
  end

  // Accumulate one bit wider than ACC_W; a mismatch of the top two bits is overflow.
  always_comb begin
    acc_wide = {acc_reg[ACC_W-1], acc_reg} + ACC_W1'(sum_reg);
    this_ovf = acc_wide[ACC_W] ^ acc_wide[ACC_W-1];
    acc_next = acc_wide[ACC_W-1:0];
    if ((SATURATE != 0) && this_ovf) begin
      acc_next = acc_wide[ACC_W] ? ACC_MIN : ACC_MAX;
    end
    ovf_next = ovf_reg | this_ovf;
  end

  // A stage: update the accumulator; on the last beat hand the total over and restart from zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_reg       <= '0;
      ovf_reg       <= 1'b0;
      res_valid_reg <= 1'b0;
      res_data_reg  <= '0;
      res_ovf_reg   <= 1'b0;
    end else if (en) begin
      res_valid_reg <= s_valid_reg & s_last_reg;
      if (s_valid_reg) begin
        if (s_last_reg) begin
          res_data_reg <= acc_next;
          res_ovf_reg  <= ovf_next;
          acc_reg      <= '0;
          ovf_reg      <= 1'b0;
        end else begin
          acc_reg      <= acc_next;
          ovf_reg      <= ovf_next;
        end
      end
    end
  end

  // Output register: holds the result stable until it is consumed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_reg <= 1'b0;
      out_data_reg  <= '0;
      out_ovf_reg   <= 1'b0;
    end else if (en) begin
      out_valid_reg <= res_valid_reg;
      if (res_valid_reg) begin
        out_data_reg <= res_data_reg;
        out_ovf_reg  <= res_ovf_reg;
      end
    end
  end

  assign out_valid = out_valid_reg;
  assign out_data  = out_data_reg;
  assign out_ovf   = out_ovf_reg;

endmodule

// File: tb/tb_mac_vec_acc.sv
// Bench for mac_vec_acc: three instances (32-bit saturating, 18-bit
// saturating, 18-bit wrapping) share one stimulus stream; each result is
// compared with a table expectation or an arithmetic reference model.
module tb_mac_vec_acc;

  localparam int NCFG = 3;

  typedef struct {
    longint data;
    bit     ovf;
  } res_t;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    bit          last;
    bit          gap;
    longint      exp_data [NCFG];
    bit          exp_ovf  [NCFG];
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_last = 1'b0;
  logic        out_ready = 1'b1;
  logic [31:0] in_a = '0;
  logic [31:0] in_b = '0;

  logic   in_ready_v  [NCFG];
  logic   out_valid_v [NCFG];
  logic   out_ovf_v   [NCFG];
  longint out_data_v  [NCFG];

  int n_checks = 0;
  int n_errors = 0;

  res_t   exp_q [NCFG][$];
  longint m_acc [NCFG];
  bit     m_ovf [NCFG];
  vec_t   tbl   [$];
  bit     rand_done;

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < NCFG; gi++) begin : g_dut
    localparam int AW = (gi == 0) ? 32 : 18;
    logic [AW-1:0] od;
    logic          ir;
    logic          ov;
    logic          oo;
    mac_vec_acc #(
      .LANES    (4),
      .IN_W     (8),
      .ACC_W    (AW),
      .SATURATE ((gi == 2) ? 0 : 1)
    ) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (ir),
      .in_a      (in_a),
      .in_b      (in_b),
      .in_last   (in_last),
      .out_valid (ov),
      .out_ready (out_ready),
      .out_data  (od),
      .out_ovf   (oo)
    );
    assign in_ready_v[gi]  = ir;
    assign out_valid_v[gi] = ov;
    assign out_ovf_v[gi]   = oo;
    assign out_data_v[gi]  = longint'(signed'(od));
  end

  function automatic int cfg_w(input int c);
    return (c == 0) ? 32 : 18;
  endfunction

  function automatic bit cfg_sat(input int c);
    return (c != 2);
  endfunction

  function automatic logic [31:0] pack(input int x0, input int x1, input int x2, input int x3);
    return {8'(x3), 8'(x2), 8'(x1), 8'(x0)};
  endfunction

  function automatic longint dotp(input logic [31:0] a, input logic [31:0] b);
    longint s = 0;
    for (int i = 0; i < 4; i++) begin
      s += longint'(byte'(a[i*8 +: 8])) * longint'(byte'(b[i*8 +: 8]));
    end
    return s;
  endfunction

  task automatic check(input string name, input longint act, input longint expv);
    n_checks++;
    if (act !== expv) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, expv);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_errors++;
    $display("FAIL %s: bound expired, got timeout, expected event", name);
  endtask

  // Reference model: plain arithmetic accumulation of each dot product.
  task automatic model_reset();
    for (int c = 0; c < NCFG; c++) begin
      m_acc[c] = 0;
      m_ovf[c] = 1'b0;
      exp_q[c].delete();
    end
  endtask

  task automatic model_beat(input logic [31:0] a, input logic [31:0] b, input bit last);
    longint t, lo, hi, m;
    res_t   r;
    for (int c = 0; c < NCFG; c++) begin
      lo = -(64'sd1 <<< (cfg_w(c) - 1));
      hi = -lo - 1;
      m  = 64'sd1 <<< cfg_w(c);
      t  = m_acc[c] + dotp(a, b);
      if (t > hi || t < lo) begin
        m_ovf[c] = 1'b1;
        if (cfg_sat(c)) begin
          t = (t > hi) ? hi : lo;
        end else begin
          t = t % m;
          if (t > hi) t -= m;
          if (t < lo) t += m;
        end
      end
      m_acc[c] = t;
      if (last) begin
        r.data = t;
        r.ovf  = m_ovf[c];
        exp_q[c].push_back(r);
        m_acc[c] = 0;
        m_ovf[c] = 1'b0;
      end
    end
  endtask

  // Offer one beat and return at the clock edge that accepts it.
  task automatic send(input logic [31:0] a, input logic [31:0] b, input bit last);
    bit ok;
    int k;
    @(negedge clk);
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    in_last  = last;
    #1;
    ok = in_ready_v[0];
    k  = 0;
    while (!ok && k < 300) begin
      @(negedge clk);
      #1;
      ok = in_ready_v[0];
      k++;
    end
    if (!ok) fail_now("send_in_ready");
    @(posedge clk);
  endtask

  task automatic idle(input int n);
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
    repeat (n - 1) @(negedge clk);
  endtask

  // Consumes results on each handshake and compares them with the expectation queues.
  task automatic monitor();
    res_t r;
    forever begin
      @(negedge clk);
      #3;
      if (rst_n && out_ready) begin
        for (int c = 0; c < NCFG; c++) begin
          if (out_valid_v[c]) begin
            if (exp_q[c].size() == 0) begin
              n_checks++;
              n_errors++;
              $display("FAIL unexpected_result cfg%0d: got %0d, expected no result", c, out_data_v[c]);
            end else begin
              r = exp_q[c].pop_front();
              check($sformatf("result_data cfg%0d", c), out_data_v[c], r.data);
              check($sformatf("result_ovf cfg%0d", c), longint'(out_ovf_v[c]), longint'(r.ovf));
              $display("result cfg%0d: data=%0d ovf=%0d", c, out_data_v[c], out_ovf_v[c]);
            end
          end
        end
      end
    end
  endtask

  task automatic add_vec(input int a0, input int a1, input int a2, input int a3,
                         input int b0, input int b1, input int b2, input int b3,
                         input bit last, input bit gap,
                         input longint e0, input bit o0, input longint e1, input bit o1,
                         input longint e2, input bit o2);
    vec_t v;
    v.a = pack(a0, a1, a2, a3);
    v.b = pack(b0, b1, b2, b3);
    v.last = last;
    v.gap  = gap;
    v.exp_data[0] = e0; v.exp_ovf[0] = o0;
    v.exp_data[1] = e1; v.exp_ovf[1] = o1;
    v.exp_data[2] = e2; v.exp_ovf[2] = o2;
    tbl.push_back(v);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int k;
    res_t r;
    logic [31:0] ra, rb;

    // ---------------- reset state ----------------
    model_reset();
    #1;
    for (int c = 0; c < NCFG; c++) begin
      check($sformatf("reset_out_valid cfg%0d", c), longint'(out_valid_v[c]), 0);
      check($sformatf("reset_out_data cfg%0d", c), out_data_v[c], 0);
      check($sformatf("reset_out_ovf cfg%0d", c), longint'(out_ovf_v[c]), 0);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("reset_in_ready", longint'(in_ready_v[0]), 1);
    fork monitor(); join_none

    // ---------------- latency of a single-beat dot product ----------------
    send(pack(1, 2, 3, 4), pack(5, 6, 7, 8), 1'b1);
    for (int c = 0; c < NCFG; c++) begin
      r.data = 70; r.ovf = 1'b0;
      exp_q[c].push_back(r);
    end
    idle(1);
    for (int e = 1; e <= 3; e++) begin
      @(posedge clk);
      #1;
      check($sformatf("latency_edge%0d_out_valid", e), longint'(out_valid_v[0]), (e == 3) ? 1 : 0);
    end
    idle(4);

    // ---------------- directed table ----------------
    add_vec(-1, -1, -1, -1, 2, 2, 2, 2, 0, 0, 0, 0, 0, 0, 0, 0);
    add_vec(-1, -1, -1, -1, 2, 2, 2, 2, 0, 1, 0, 0, 0, 0, 0, 0);
    add_vec(-1, -1, -1, -1, 2, 2, 2, 2, 1, 0, -24, 0, -24, 0, -24, 0);
    add_vec(1, 1, 1, 1, 1, 1, 1, 1, 1, 0, 4, 0, 4, 0, 4, 0);
    add_vec(-128, -128, -128, -128, -128, -128, -128, -128, 0, 0, 0, 0, 0, 0, 0, 0);
    add_vec(-128, -128, -128, -128, -128, -128, -128, -128, 0, 0, 0, 0, 0, 0, 0, 0);
    add_vec(-128, -128, -128, -128, -128, -128, -128, -128, 0, 1, 0, 0, 0, 0, 0, 0);
    add_vec(-128, -128, -128, -128, -128, -128, -128, -128, 1, 0, 262144, 0, 131071, 1, 0, 1);
    add_vec(1, 1, 1, 1, 1, 1, 1, 1, 1, 0, 4, 0, 4, 0, 4, 0);
    add_vec(127, -128, 127, -128, 127, 127, -128, -128, 1, 0, 1, 0, 1, 0, 1, 0);
    add_vec(-128, -128, -128, -128, 127, 127, 127, 127, 1, 1, -65024, 0, -65024, 0, -65024, 0);
    for (int i = 0; i < tbl.size(); i++) begin
      if (tbl[i].gap) idle(2);
      send(tbl[i].a, tbl[i].b, tbl[i].last);
      $display("table beat %0d: a=%h b=%h last=%0d", i, tbl[i].a, tbl[i].b, tbl[i].last);
      if (tbl[i].last) begin
        for (int c = 0; c < NCFG; c++) begin
          r.data = tbl[i].exp_data[c];
          r.ovf  = tbl[i].exp_ovf[c];
          exp_q[c].push_back(r);
        end
      end
    end
    idle(8);

    // ---------------- backpressure ----------------
    model_reset();
    out_ready = 1'b0;
    fork
      begin
        for (int i = 0; i < 6; i++) begin
          ra = $urandom();
          rb = $urandom();
          send(ra, rb, (i % 2 == 0) || (i == 5));
          model_beat(ra, rb, (i % 2 == 0) || (i == 5));
        end
        idle(1);
      end
      begin
        k = 0;
        do begin
          @(negedge clk);
          #2;
          k++;
        end while (!out_valid_v[0] && k < 50);
        if (!out_valid_v[0]) fail_now("bp_wait_valid");
        for (int cyc = 0; cyc < 5; cyc++) begin
          if (cyc > 0) begin
            @(negedge clk);
            #2;
          end
          for (int c = 0; c < NCFG; c++) begin
            check($sformatf("bp_in_ready cfg%0d", c), longint'(in_ready_v[c]), 0);
            check($sformatf("bp_out_valid cfg%0d", c), longint'(out_valid_v[c]), 1);
            if (exp_q[c].size() > 0)
              check($sformatf("bp_out_data cfg%0d", c), out_data_v[c], exp_q[c][0].data);
          end
        end
        @(negedge clk);
        out_ready = 1'b1;
      end
    join
    idle(10);

    // ---------------- asynchronous reset mid dot product ----------------
    model_reset();
    send(pack(1, 1, 1, 1), pack(1, 1, 1, 1), 1'b1);
    send(pack(3, 3, 3, 3), pack(3, 3, 3, 3), 1'b0);
    send(pack(5, 5, 5, 5), pack(5, 5, 5, 5), 1'b0);
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    k = 0;
    while (!out_valid_v[0] && k < 20) begin
      @(negedge clk);
      k++;
    end
    if (!out_valid_v[0]) fail_now("rst_wait_valid");
    rst_n = 1'b0;
    #1;
    for (int c = 0; c < NCFG; c++) begin
      check($sformatf("async_rst_out_valid cfg%0d", c), longint'(out_valid_v[c]), 0);
      check($sformatf("async_rst_out_data cfg%0d", c), out_data_v[c], 0);
    end
    model_reset();
    @(negedge clk);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    #1;
    check("post_rst_in_ready", longint'(in_ready_v[0]), 1);
    send(pack(1, 2, 3, 4), pack(5, 6, 7, 8), 1'b1);
    model_beat(pack(1, 2, 3, 4), pack(5, 6, 7, 8), 1'b1);
    idle(8);

    // ---------------- randomized traffic with random stalls ----------------
    model_reset();
    rand_done = 1'b0;
    fork
      begin
        int len;
        for (int d = 0; d < 40; d++) begin
          len = $urandom_range(1, 4);
          for (int bt = 0; bt < len; bt++) begin
            if ($urandom_range(0, 4) == 0) idle(1);
            ra = $urandom();
            rb = ($urandom_range(0, 3) == 0) ? pack(-128, -128, -128, -128) : $urandom();
            if ($urandom_range(0, 3) == 0) ra = pack(-128, -128, -128, -128);
            send(ra, rb, bt == len - 1);
            model_beat(ra, rb, bt == len - 1);
          end
        end
        idle(1);
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          @(negedge clk);
          out_ready = ($urandom_range(0, 3) != 0);
        end
        out_ready = 1'b1;
      end
    join

    // ---------------- drain ----------------
    k = 0;
    while ((exp_q[0].size() + exp_q[1].size() + exp_q[2].size()) != 0 && k < 200) begin
      @(negedge clk);
      k++;
    end
    check("drain_pending_results", longint'(exp_q[0].size() + exp_q[1].size() + exp_q[2].size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
